huffman_param: RTL and testbench
================================

# huffman_param

Parametrised Huffman coder for the image-statistics path. It tallies a frame of NSAMP symbols (1..NSYM) from the gray-level stream and publishes the per-symbol counts. It then builds a Huffman code by NSYM-1 deterministic merge passes and publishes per-symbol code words and length masks. It rearms automatically for back-to-back frames.

## Interface
Parameters:
- NSYM, 6: symbol alphabet size, 2..8; legal symbols are 1..NSYM.
- NSAMP, 100: samples per frame; must be ≤ 2^CW-1.
- CW, 8: count/weight width.
- CODEW, 8: code/mask width; must be ≥ NSYM-1.

Ports (clock and reset first):
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  sample strobe; accepted only when in_ready=1.
- in_data  in  8  symbol value.
- in_ready  out  1  high in COUNT and DONE states.
- cnt_valid  out  1  one-cycle pulse; cnt_flat is final.
- cnt_flat  out  NSYM*CW  count of symbol k at bits [k*CW-1 -: CW].
- code_valid  out  1  level; hc_flat and m_flat are final.
- hc_flat  out  NSYM*CODEW  code of symbol k, LSB-aligned, MSB = root-side bit.
- m_flat  out  NSYM*CODEW  mask of symbol k, (1<<len)-1.
- sym_err  out  1  sticky: an out-of-range symbol was seen this frame.

## Operation
- States: COUNT, SCAN, MERGE, DONE. Reset enters COUNT.
- Reset values: all counts, codes, masks, sample counter, cnt_valid, code_valid and sym_err are 0; in_ready is 1.
- COUNT:
  - Each accepted sample increments the sample counter.
  - A legal symbol increments its count.
  - A symbol of 0 or >NSYM is not tallied, still counts toward NSAMP, and sets sym_err.
- On acceptance of the NSAMP-th sample:
  - cnt_valid pulses on the next cycle.
  - The node table initialises: node k has weight = count k, key = k, active, members = {k}.
  - The state moves to SCAN.
- SCAN walks nodes 1..NSYM, one per cycle, tracking the two first-ranked active nodes by (weight ascending, key descending). The first-ranked node is lo; the second is hi.
- MERGE, one cycle:
  - Every member of lo: code |= 1<<len, len += 1.
  - Every member of hi: len += 1; the code bit is 0.
  - hi takes weight lo+hi, key min(keys), and lo's members; lo is deactivated.
  - Zero-count symbols merge normally.
- Flow: after NSYM-1 merges go to DONE, otherwise return to SCAN. code_valid is high throughout DONE.
- DONE, first accepted sample:
  - Counts, codes, masks and sym_err are cleared, and this sample is tallied as the first of the new frame.
  - code_valid falls on the next cycle and the state becomes COUNT.
- in_valid is ignored while in_ready=0 (SCAN and MERGE). Samples offered then are dropped, not stalled.
- Width rules:
  - Weight sums stay ≤ NSAMP and fit in CW bits.
  - Code length is ≤ NSYM-1 ≤ CODEW.
  - Upper unused bits of hc and m are 0.

## Timing
- Let T be the edge that accepts sample NSAMP. cnt_valid is high for exactly the cycle after T, and cnt_flat is stable from then until the next frame's first sample.
- Each pass is NSYM SCAN cycles plus 1 MERGE cycle. code_valid rises (NSYM-1)(NSYM+1) cycles after cnt_valid rises; for NSYM=6 that is 35 cycles.
- in_ready deasserts in the cycle after T and reasserts with code_valid.
- Asynchronous reset mid-frame or mid-merge:
  - All state is discarded, with outputs at their reset values immediately.
  - The next accepted sample is sample 1.

## Test plan
- NSYM=6, NSAMP=100, counts 40,30,10,10,6,4 for s1..s6:
  - Required code/length: s1 1/1, s2 00/2, s3 011/3, s4 0100/4, s5 01010/5, s6 01011/5.
  - Required masks: 1,3,7,15,31,31.
  - cnt_valid must precede code_valid by 35 cycles.
- Equal counts, NSYM=4, NSAMP=8, two of each symbol:
  - Tie-break yields every length 2.
  - Required codes: s1=00, s2=01, s3=10, s4=11.
- Out-of-range symbols: 100 samples with five 7s and s1 ×95:
  - Required: sym_err=1, cnt1=95, counts 2..6 = 0.
  - Zero-count symbols still receive prefix-free codes.
- Back-to-back frames: in_valid held high through DONE:
  - The first DONE sample starts frame 2, and frame 2's counts include it.
  - Samples offered during SCAN/MERGE are not counted.
- Reset asserted mid-MERGE:
  - All outputs 0 and in_ready=1 in the same cycle.
  - A following clean frame reproduces the golden codes above.
- NSYM=2, NSAMP=3, counts 2,1:
  - cnt_valid to code_valid is 3 cycles.
  - Required: hc1=0, hc2=1, m1=m2=1.

Source files
------------

// File: rtl/huffman_param.sv
// huffman_param: per-frame symbol histogram followed by an iterative Huffman code build.
// Each merge pass scans the node table for the two lowest-ranked active nodes, then merges them.
module huffman_param #(
    parameter int NSYM  = 6,
    parameter int NSAMP = 100,
    parameter int CW    = 8,
    parameter int CODEW = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  cnt_valid,
    output logic [NSYM*CW-1:0]    cnt_flat,
    output logic                  code_valid,
    output logic [NSYM*CODEW-1:0] hc_flat,
    output logic [NSYM*CODEW-1:0] m_flat,
    output logic                  sym_err
);
    localparam int IW = $clog2(NSYM);
    typedef enum logic [1:0] {COUNT = 2'd0, SCAN = 2'd1, MERGE = 2'd2, DONE = 2'd3} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt [NSYM];
    logic [CW-1:0] cnt_nx [NSYM];
    logic [CW-1:0] weight [NSYM];
    logic [IW-1:0] key [NSYM];
    logic [NSYM-1:0] mem [NSYM];
    logic [CODEW-1:0] hc [NSYM];
    logic [CODEW-1:0] m [NSYM];
    logic [NSYM-1:0] act;
    logic [CW-1:0] n, n_nx;
    logic [IW-1:0] idx, pass, lo, hi;
    logic lo_ok, hi_ok, acc, fresh, legal, last;

    // rank order: lighter first, equal weights broken by larger key first
    function automatic logic ahead(input logic [CW-1:0] wa, input logic [IW-1:0] ka,
                                   input logic [CW-1:0] wb, input logic [IW-1:0] kb);
        return wa < wb || (wa == wb && ka > kb);
    endfunction

    always_comb begin
        acc   = in_valid && in_ready;
        fresh = state == DONE;
        legal = in_data != '0 && in_data <= 8'(NSYM);
        n_nx  = (fresh ? '0 : n) + CW'(1);
        last  = acc && n_nx == CW'(NSAMP);
        for (int k = 0; k < NSYM; k++)
            cnt_nx[k] = (fresh ? '0 : cnt[k]) + CW'(in_data == 8'(k + 1));
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= COUNT;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        unique case (state)
            COUNT, DONE: if (acc) state_nx = last ? SCAN : COUNT;
            SCAN:        if (idx == IW'(NSYM - 1)) state_nx = MERGE;
            MERGE:       state_nx = pass == IW'(NSYM - 2) ? DONE : SCAN;
        endcase
    end

    always_comb begin
        in_ready   = state == COUNT || state == DONE;
        code_valid = state == DONE;
        cnt_valid  = state == SCAN && pass == '0 && idx == '0;
        for (int k = 0; k < NSYM; k++) begin
            cnt_flat[k*CW +: CW]      = cnt[k];
            hc_flat[k*CODEW +: CODEW] = hc[k];
            m_flat[k*CODEW +: CODEW]  = m[k];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n       <= '0;
            sym_err <= 1'b0;
            idx     <= '0;
            pass    <= '0;
            lo      <= '0;
            hi      <= '0;
            lo_ok   <= 1'b0;
            hi_ok   <= 1'b0;
            act     <= '0;
            for (int k = 0; k < NSYM; k++) begin
                cnt[k]    <= '0;
                weight[k] <= '0;
                key[k]    <= '0;
                mem[k]    <= '0;
                hc[k]     <= '0;
                m[k]      <= '0;
            end
        end else begin
            unique case (state)
                COUNT, DONE: if (acc) begin
                    n       <= n_nx;
                    sym_err <= (sym_err && !fresh) || !legal;
                    idx     <= '0;
                    pass    <= '0;
                    lo_ok   <= 1'b0;
                    hi_ok   <= 1'b0;
                    act     <= '1;
                    // node table tracks the running counts so it is ready when the frame closes
                    for (int k = 0; k < NSYM; k++) begin
                        cnt[k]    <= cnt_nx[k];
                        weight[k] <= cnt_nx[k];
                        key[k]    <= IW'(k);
                        mem[k]    <= NSYM'(1) << k;
                        if (fresh) begin
                            hc[k] <= '0;
                            m[k]  <= '0;
                        end
                    end
                end
                SCAN: begin
                    idx <= idx + IW'(1);
                    if (act[idx]) begin
                        if (!lo_ok || ahead(weight[idx], key[idx], weight[lo], key[lo])) begin
                            hi    <= lo;
                            hi_ok <= lo_ok;
                            lo    <= idx;
                            lo_ok <= 1'b1;
                        end else if (!hi_ok || ahead(weight[idx], key[idx], weight[hi], key[hi])) begin
                            hi    <= idx;
                            hi_ok <= 1'b1;
                        end
                    end
                end
                MERGE: begin
                    for (int k = 0; k < NSYM; k++) begin
                        if (mem[lo][k] || mem[hi][k]) m[k] <= (m[k] << 1) | CODEW'(1);
                        if (mem[lo][k]) hc[k] <= hc[k] | (m[k] + CODEW'(1));
                    end
                    weight[hi] <= weight[lo] + weight[hi];
                    key[hi]    <= key[lo] < key[hi] ? key[lo] : key[hi];
                    mem[hi]    <= mem[hi] | mem[lo];
                    act[lo]    <= 1'b0;
                    pass       <= pass + IW'(1);
                    idx        <= '0;
                    lo_ok      <= 1'b0;
                    hi_ok      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_huffman_param.sv
// tb_huffman_param: drives frames into three configurations of huffman_param and compares
// counts, codes, masks and timing against a procedural Huffman model.
module tb_huffman_param;
    logic clk = 1'b0;
    logic reset;
    logic vin [3];
    logic [7:0] din [3];
    logic rdy [3];
    logic kv [3];
    logic cv [3];
    logic err [3];
    logic [63:0] cf [3];
    logic [63:0] hf [3];
    logic [63:0] mf [3];
    logic [47:0] cnt6, hc6, m6;
    logic [31:0] cnt4, hc4, m4;
    logic [15:0] cnt2, hc2, m2;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    huffman_param #(.NSYM(6), .NSAMP(100), .CW(8), .CODEW(8)) u6 (
        .clk(clk), .reset(reset), .in_valid(vin[0]), .in_data(din[0]), .in_ready(rdy[0]),
        .cnt_valid(kv[0]), .cnt_flat(cnt6), .code_valid(cv[0]), .hc_flat(hc6), .m_flat(m6),
        .sym_err(err[0]));
    huffman_param #(.NSYM(4), .NSAMP(8), .CW(8), .CODEW(8)) u4 (
        .clk(clk), .reset(reset), .in_valid(vin[1]), .in_data(din[1]), .in_ready(rdy[1]),
        .cnt_valid(kv[1]), .cnt_flat(cnt4), .code_valid(cv[1]), .hc_flat(hc4), .m_flat(m4),
        .sym_err(err[1]));
    huffman_param #(.NSYM(2), .NSAMP(3), .CW(8), .CODEW(8)) u2 (
        .clk(clk), .reset(reset), .in_valid(vin[2]), .in_data(din[2]), .in_ready(rdy[2]),
        .cnt_valid(kv[2]), .cnt_flat(cnt2), .code_valid(cv[2]), .hc_flat(hc2), .m_flat(m2),
        .sym_err(err[2]));

    assign cf[0] = 64'(cnt6);
    assign hf[0] = 64'(hc6);
    assign mf[0] = 64'(m6);
    assign cf[1] = 64'(cnt4);
    assign hf[1] = 64'(hc4);
    assign mf[1] = 64'(m4);
    assign cf[2] = 64'(cnt2);
    assign hf[2] = 64'(hc2);
    assign mf[2] = 64'(m2);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic ahead(input int wa, input int ka, input int wb, input int kb);
        return wa < wb || (wa == wb && ka > kb);
    endfunction

    // Huffman build on whole-node sets: pick the best active node, then the best of the rest
    function automatic void huff(input int ns, input int c[8], output logic [63:0] ehc,
                                 output logic [63:0] em);
        int w[8], key[8], mem[8], code[8], len[8];
        bit act[8];
        int lo, hi;
        for (int k = 0; k < 8; k++) begin
            w[k] = c[k]; key[k] = k; mem[k] = 1 << k; act[k] = k < ns; code[k] = 0; len[k] = 0;
        end
        for (int p = 0; p < ns - 1; p++) begin
            lo = -1;
            for (int k = 0; k < ns; k++)
                if (act[k] && (lo < 0 || ahead(w[k], key[k], w[lo], key[lo]))) lo = k;
            hi = -1;
            for (int k = 0; k < ns; k++)
                if (act[k] && k != lo && (hi < 0 || ahead(w[k], key[k], w[hi], key[hi]))) hi = k;
            for (int s = 0; s < ns; s++) begin
                if (mem[lo][s]) begin code[s] |= 1 << len[s]; len[s]++; end
                if (mem[hi][s]) len[s]++;
            end
            w[hi] += w[lo];
            key[hi] = key[lo] < key[hi] ? key[lo] : key[hi];
            mem[hi] |= mem[lo];
            act[lo] = 0;
        end
        ehc = '0;
        em = '0;
        for (int s = 0; s < ns; s++) begin
            ehc[s*8 +: 8] = 8'(code[s]);
            em[s*8 +: 8] = 8'((1 << len[s]) - 1);
        end
    endfunction

    function automatic void make(input int c[8], input int n7, output int q[$]);
        int t, j;
        q = {};
        for (int k = 0; k < 8; k++) for (int r = 0; r < c[k]; r++) q.push_back(k + 1);
        for (int r = 0; r < n7; r++) q.push_back(7);
        for (int i = q.size() - 1; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = q[i]; q[i] = q[j]; q[j] = t;
        end
    endfunction

    task automatic run(input int u, input int ns, input int q[$], input bit hold, input bit chain);
        int c[8];
        bit e;
        int cyc;
        logic [63:0] ec, ehc, em;
        c = '{default: 0};
        e = 0;
        ec = '0;
        foreach (q[i]) if (q[i] >= 1 && q[i] <= ns) c[q[i] - 1]++; else e = 1;
        for (int k = 0; k < ns; k++) ec[k*8 +: 8] = 8'(c[k]);
        for (int i = 0; i < q.size(); i++) begin
            vin[u] = 1'b1;
            din[u] = 8'(q[i]);
            @(negedge clk);
            if (i == 0 && chain) begin
                check("code_valid_fall", 64'(cv[u]), 64'd0);
                check("codes_cleared", hf[u], 64'd0);
            end
        end
        vin[u] = 1'b0;
        check("cnt_valid_pulse", 64'(kv[u]), 64'd1);
        check("ready_low", 64'(rdy[u]), 64'd0);
        check("counts", cf[u], ec);
        check("sym_err", 64'(err[u]), 64'(e));
        cyc = 0;
        while (!cv[u] && cyc < 200) begin
            if (hold) begin
                vin[u] = 1'b1;
                din[u] = 8'($urandom_range(0, 9));
            end
            @(negedge clk);
            cyc++;
            if (cyc == 1) check("cnt_valid_single", 64'(kv[u]), 64'd0);
        end
        vin[u] = 1'b0;
        check("code_latency", 64'(cyc), 64'((ns - 1) * (ns + 1)));
        huff(ns, c, ehc, em);
        check("codes", hf[u], ehc);
        check("masks", mf[u], em);
        check("ready_high", 64'(rdy[u]), 64'd1);
        check("counts_hold", cf[u], ec);
    endtask

    task automatic check_idle(input int u);
        check("rst_ready", 64'(rdy[u]), 64'd1);
        check("rst_cnt_valid", 64'(kv[u]), 64'd0);
        check("rst_code_valid", 64'(cv[u]), 64'd0);
        check("rst_counts", cf[u], 64'd0);
        check("rst_codes", hf[u], 64'd0);
        check("rst_masks", mf[u], 64'd0);
        check("rst_sym_err", 64'(err[u]), 64'd0);
    endtask

    task automatic golden(input bit chain);
        int q[$];
        make('{40, 30, 10, 10, 6, 4, 0, 0}, 0, q);
        run(0, 6, q, 0, chain);
        check("gold_counts", cf[0], 64'h04060A0A1E28);
        check("gold_codes", hf[0], 64'h0B0A04030001);
        check("gold_masks", mf[0], 64'h1F1F0F070301);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int q[$];
        int c[8];
        int r;
        reset = 1'b1;
        for (int u = 0; u < 3; u++) begin vin[u] = 1'b0; din[u] = 8'd0; end
        repeat (3) @(negedge clk);
        check_idle(0);
        check_idle(2);
        reset = 1'b0;
        golden(0);
        make('{95, 0, 0, 0, 0, 0, 0, 0}, 5, q);
        run(0, 6, q, 1, 1);
        check("oor_sym_err", 64'(err[0]), 64'd1);
        check("oor_counts", cf[0], 64'h5F);
        for (int f = 0; f < 3; f++) begin
            q = {};
            for (int i = 0; i < 100; i++) begin
                r = int'($urandom_range(0, 19));
                q.push_back(r < 18 ? 1 + r % 6 : (r == 18 ? 0 : int'($urandom_range(7, 255))));
            end
            run(0, 6, q, 1, 1);
        end
        make('{2, 2, 2, 2, 0, 0, 0, 0}, 0, q);
        run(1, 4, q, 0, 0);
        check("eq_codes", hf[1], 64'h03020100);
        check("eq_masks", mf[1], 64'h03030303);
        q = {1, 2, 1};
        run(2, 2, q, 0, 0);
        check("n2_codes", hf[2], 64'h0100);
        check("n2_masks", mf[2], 64'h0101);
        // interrupt the third merge pass of an out-of-range frame
        make('{95, 0, 0, 0, 0, 0, 0, 0}, 5, q);
        foreach (q[i]) begin
            vin[0] = 1'b1;
            din[0] = 8'(q[i]);
            @(negedge clk);
        end
        vin[0] = 1'b0;
        repeat (20) @(negedge clk);
        check("pre_rst_err", 64'(err[0]), 64'd1);
        check("pre_rst_busy", 64'(rdy[0]), 64'd0);
        #2 reset = 1'b1;
        #1 check_idle(0);
        @(negedge clk);
        reset = 1'b0;
        golden(0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
